render_fb_writer: RTL and testbench
===================================

Name: render_fb_writer

Overview:
- Sits directly downstream of full_renderer and consumes its pixel stream (24-bit RGB plus hcount/vcount tags).
- Converts each pixel to RGB444 and computes its framebuffer address, then drives port A of a double-banked (2 × region) dual-port RAM.
- Swaps front/back banks only at a display frame boundary once a full frame has been rendered, so scan-out never shows a partially drawn frame.

Parameters:
- START_X, 390, first rendered column (inclusive)
- START_Y, 390, first rendered row (inclusive)
- END_X, 634, last rendered column + 1
- END_Y, 765, last rendered row + 1
- ADDR_WIDTH, 18, RAM address width; must hold 2*(END_X-START_X)*(END_Y-START_Y)-1

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous, active-high reset
- pixel_tdata  input  24  renderer pixel {R[7:0],G[7:0],B[7:0]}
- pixel_tvalid  input  1  pixel_tdata, hcount_in and vcount_in are valid
- pixel_tready  output  1  block accepts a pixel this cycle
- hcount_in  input  11  column tag of the pixel
- vcount_in  input  10  row tag of the pixel
- display_nf_in  input  1  one-cycle new-frame pulse from the scan-out signal generator
- wr_addr_out  output  ADDR_WIDTH  RAM port A address
- wr_data_out  output  12  RAM port A data {R[7:4],G[7:4],B[7:4]}
- wr_en_out  output  1  RAM port A write enable
- rd_bank_out  output  1  bank the scan-out side reads; scan-out adds rd_bank_out*FRAME_PIXELS to its address
- frame_done_out  output  1  one-cycle pulse on bank swap
- frames_out  output  16  completed-frame counter, wraps
- dropped_out  output  16  out-of-region pixels accepted, saturates at 16'hFFFF

Behaviour:
- Derived constants: W = END_X-START_X; FRAME_PIXELS = W*(END_Y-START_Y). Defaults give W = 244 and FRAME_PIXELS = 91500.
- State machine: FILL, WAIT_SWAP.
- Reset (async, immediate): state = FILL, rd_bank_out = 0, internal wr_bank = 1. wr_en_out, frame_done_out, frames_out, dropped_out, wr_addr_out and wr_data_out are all 0.
- pixel_tready is combinational and equals (state == FILL). A pixel is accepted when pixel_tvalid && pixel_tready.
- In-region pixel: START_X ≤ h < END_X and START_Y ≤ v < END_Y.
- Accepted in-region pixel: on the next clock edge, wr_en_out = 1 for exactly one cycle.
  - wr_addr_out = (h-START_X) + (v-START_Y)*W + (wr_bank ? FRAME_PIXELS : 0), computed at ADDR_WIDTH bits.
  - wr_data_out = {tdata[23:20], tdata[15:12], tdata[7:4]}.
  - Write latency is 1 cycle. Back-to-back accepts give back-to-back writes.
- Accepted out-of-region pixel: no write; dropped_out increments by 1, saturating at 16'hFFFF.
- Cycles with no accept: wr_en_out = 0. wr_addr_out and wr_data_out hold their last value.
- Frame completion: an accepted pixel with h = END_X-1 and v = END_Y-1 moves FILL → WAIT_SWAP on the next edge. Its write still happens normally.
- Out-of-order arrival is not checked; only the last-coordinate pixel ends a frame.
- In FILL, display_nf_in is ignored.
- In WAIT_SWAP with display_nf_in = 1, on the next edge:
  - rd_bank_out toggles and wr_bank toggles; wr_bank always equals ~rd_bank_out.
  - frames_out increments (wraps).
  - frame_done_out pulses high for that one cycle.
  - state returns to FILL.
- Simultaneous events:
  - display_nf_in in the same cycle the last pixel is accepted: ignored, because state is still FILL; the swap waits for the next pulse.
  - display_nf_in during WAIT_SWAP while pixel_tvalid is high: the pixel is not accepted that cycle (tready is low).
- Mid-operation reset: state, banks and counters return to reset values at once. Any pending write is cancelled (wr_en_out = 0). RAM contents are not cleared.

Test Plan:
- Reset, then accept pixel h=390, v=390, tdata=24'hABCDEF → one cycle later wr_en_out=1, wr_addr_out=91500, wr_data_out=12'hACE; rd_bank_out=0.
- Accept h=391, v=391 → wr_addr_out=91745. Accept h=389, v=400 → no write, dropped_out=1. Force 70000 out-of-region accepts → dropped_out=16'hFFFF.
- Stream the full 244×375 region in raster order with tvalid held high:
  - last write has wr_addr_out=182999;
  - pixel_tready=0 from the next cycle;
  - a display_nf_in pulse 10 cycles later → rd_bank_out=1, frame_done_out pulses once, frames_out=1, tready=1;
  - next frame's pixel (390,390) writes to address 0.
- Pulse display_nf_in in the same cycle as accepting (633,764) → no swap; the following pulse causes the swap.
- Pulse display_nf_in during FILL only → rd_bank_out and frames_out unchanged.
- Assert rst_in asynchronously in WAIT_SWAP with tvalid high → all outputs 0 and tready=1 immediately; after release the first write targets bank 1 (address 91500 for pixel (390,390)).

Source files
------------

// File: rtl/render_fb_writer.sv
// Framebuffer writer: packs renderer pixels to RGB444, addresses them into the
// back bank of a double-banked RAM and swaps banks on a display frame boundary.
module render_fb_writer #(
  parameter int START_X    = 390,
  parameter int START_Y    = 390,
  parameter int END_X      = 634,
  parameter int END_Y      = 765,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [23:0]           pixel_tdata,
  input  logic                  pixel_tvalid,
  output logic                  pixel_tready,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  display_nf_in,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [11:0]           wr_data_out,
  output logic                  wr_en_out,
  output logic                  rd_bank_out,
  output logic                  frame_done_out,
  output logic [15:0]           frames_out,
  output logic [15:0]           dropped_out
);

  localparam int W            = END_X - START_X;
  localparam int FRAME_PIXELS = W * (END_Y - START_Y);

  typedef enum logic [0:0] {
    S_FILL      = 1'b0,
    S_WAIT_SWAP = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_rd_bank;
  logic                    r_wr_en;
  logic                    r_frame_done;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [11:0]             r_wr_data;
  logic [15:0]             r_frames;
  logic [15:0]             r_dropped;

  logic                    w_wr_bank;
  logic                    w_accept;
  logic                    w_in_region;
  logic                    w_last_pixel;
  logic                    w_swap;
  logic [ADDR_WIDTH-1:0]   w_col;
  logic [ADDR_WIDTH-1:0]   w_row;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [11:0]             w_rgb444;
  logic                    w_unused_low_bits;

  // The write bank is always the one scan-out is not reading.
  assign w_wr_bank    = ~r_rd_bank;
  assign pixel_tready = (r_state == S_FILL);
  assign w_accept     = pixel_tvalid && pixel_tready;
  assign w_swap       = (r_state == S_WAIT_SWAP) && display_nf_in;

  assign w_in_region  = (hcount_in >= 11'(START_X)) && (hcount_in < 11'(END_X)) &&
                        (vcount_in >= 10'(START_Y)) && (vcount_in < 10'(END_Y));
  assign w_last_pixel = (hcount_in == 11'(END_X - 1)) && (vcount_in == 10'(END_Y - 1));

  assign w_col    = ADDR_WIDTH'(hcount_in) - ADDR_WIDTH'(START_X);
  assign w_row    = ADDR_WIDTH'(vcount_in) - ADDR_WIDTH'(START_Y);
  assign w_addr   = w_col + w_row * ADDR_WIDTH'(W) +
                    (w_wr_bank ? ADDR_WIDTH'(FRAME_PIXELS) : {ADDR_WIDTH{1'b0}});
  assign w_rgb444 = {pixel_tdata[23:20], pixel_tdata[15:12], pixel_tdata[7:4]};
  assign w_unused_low_bits = ^{pixel_tdata[19:16], pixel_tdata[11:8], pixel_tdata[3:0]};

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: the frame's last pixel closes the fill; a new-frame pulse releases it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if (w_accept && w_last_pixel) begin
          w_state_nxt = S_WAIT_SWAP;
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      S_WAIT_SWAP: begin
        if (display_nf_in) begin
          w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = S_WAIT_SWAP;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // RAM write port, bank select and status counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rd_bank    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_addr    <= {ADDR_WIDTH{1'b0}};
      r_wr_data    <= 12'd0;
      r_frames     <= 16'd0;
      r_dropped    <= 16'd0;
    end else begin
      r_wr_en      <= w_accept && w_in_region;
      r_frame_done <= w_swap;
      if (w_accept && w_in_region) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_rgb444;
      end
      if (w_accept && !w_in_region && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
      if (w_swap) begin
        r_rd_bank <= ~r_rd_bank;
        r_frames  <= r_frames + 16'd1;
      end
    end
  end

  assign wr_addr_out    = r_wr_addr;
  assign wr_data_out    = r_wr_data;
  assign wr_en_out      = r_wr_en;
  assign rd_bank_out    = r_rd_bank;
  assign frame_done_out = r_frame_done;
  assign frames_out     = r_frames;
  assign dropped_out    = r_dropped;

endmodule

// File: tb/tb_render_fb_writer.sv
// Directed testbench for render_fb_writer: each task drives one scenario and
// compares outputs against hand-computed values one cycle after the clock edge.
module tb_render_fb_writer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [23:0] pixel_tdata;
  logic        pixel_tvalid;
  logic        pixel_tready;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        display_nf_in;
  logic [17:0] wr_addr_out;
  logic [11:0] wr_data_out;
  logic        wr_en_out;
  logic        rd_bank_out;
  logic        frame_done_out;
  logic [15:0] frames_out;
  logic [15:0] dropped_out;

  int tests = 0;
  int fails = 0;

  render_fb_writer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .pixel_tdata    (pixel_tdata),
    .pixel_tvalid   (pixel_tvalid),
    .pixel_tready   (pixel_tready),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .display_nf_in  (display_nf_in),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .wr_en_out      (wr_en_out),
    .rd_bank_out    (rd_bank_out),
    .frame_done_out (frame_done_out),
    .frames_out     (frames_out),
    .dropped_out    (dropped_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic [23:0] d);
    pixel_tvalid = 1'b1;
    hcount_in    = 11'(h);
    vcount_in    = 10'(v);
    pixel_tdata  = d;
  endtask

  task automatic do_reset();
    pixel_tvalid  = 1'b0;
    display_nf_in = 1'b0;
    hcount_in     = 11'd0;
    vcount_in     = 10'd0;
    pixel_tdata   = 24'd0;
    rst_in        = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({wr_en_out, frame_done_out, rd_bank_out, wr_addr_out, wr_data_out, frames_out, dropped_out} !== '0) begin
      $display("FAIL reset_outputs: got en=%0b fd=%0b rb=%0b addr=%0d data=%h frames=%0d dropped=%0d, expected all 0",
               wr_en_out, frame_done_out, rd_bank_out, wr_addr_out, wr_data_out, frames_out, dropped_out);
      fails++;
    end
    tests++;
    if (pixel_tready !== 1'b1) begin
      $display("FAIL reset_tready: got %0b expected 1", pixel_tready); fails++;
    end
  endtask

  task automatic test_first_pixels();
    drive(390, 390, 24'hABCDEF);
    step();
    pixel_tvalid = 1'b0;
    tests++;
    if ({wr_en_out, wr_addr_out, wr_data_out, rd_bank_out} !== {1'b1, 18'd91500, 12'hACE, 1'b0}) begin
      $display("FAIL first_write: got en=%0b addr=%0d data=%h rb=%0b expected en=1 addr=91500 data=ace rb=0",
               wr_en_out, wr_addr_out, wr_data_out, rd_bank_out);
      fails++;
    end
    step();
    tests++;
    if ({wr_en_out, wr_addr_out, wr_data_out} !== {1'b0, 18'd91500, 12'hACE}) begin
      $display("FAIL idle_hold: got en=%0b addr=%0d data=%h expected en=0 addr=91500 data=ace",
               wr_en_out, wr_addr_out, wr_data_out);
      fails++;
    end
    drive(391, 391, 24'h123456);
    step();
    pixel_tvalid = 1'b0;
    tests++;
    if ({wr_en_out, wr_addr_out, wr_data_out} !== {1'b1, 18'd91745, 12'h135}) begin
      $display("FAIL second_write: got en=%0b addr=%0d data=%h expected en=1 addr=91745 data=135",
               wr_en_out, wr_addr_out, wr_data_out);
      fails++;
    end
  endtask

  task automatic test_dropped();
    drive(389, 400, 24'hFFFFFF);
    step();
    pixel_tvalid = 1'b0;
    tests++;
    if ({wr_en_out, dropped_out, wr_addr_out} !== {1'b0, 16'd1, 18'd91745}) begin
      $display("FAIL drop_one: got en=%0b dropped=%0d addr=%0d expected en=0 dropped=1 addr=91745",
               wr_en_out, dropped_out, wr_addr_out);
      fails++;
    end
    drive(634, 390, 24'h0);
    step();
    pixel_tvalid = 1'b0;
    tests++;
    if ({wr_en_out, dropped_out} !== {1'b0, 16'd2}) begin
      $display("FAIL drop_end_x: got en=%0b dropped=%0d expected en=0 dropped=2", wr_en_out, dropped_out);
      fails++;
    end
    drive(0, 0, 24'h0);
    repeat (65533) step();
    tests++;
    if (dropped_out !== 16'hFFFF) begin
      $display("FAIL drop_reach_sat: got %h expected ffff", dropped_out); fails++;
    end
    repeat (5) step();
    pixel_tvalid = 1'b0;
    tests++;
    if (dropped_out !== 16'hFFFF) begin
      $display("FAIL drop_saturate: got %h expected ffff", dropped_out); fails++;
    end
  endtask

  task automatic stream_row(input int v, input int base, input string name);
    for (int h = 390; h < 634; h++) begin
      drive(h, v, 24'h0);
      step();
      tests++;
      if ({wr_en_out, wr_addr_out} !== {1'b1, 18'(base + h - 390)}) begin
        $display("FAIL %s h=%0d: got en=%0b addr=%0d expected en=1 addr=%0d",
                 name, h, wr_en_out, wr_addr_out, base + h - 390);
        fails++;
      end
    end
  endtask

  task automatic test_frame_swap();
    do_reset();
    stream_row(390, 91500, "row_first");
    stream_row(764, 182756, "row_last");
    tests++;
    if ({pixel_tready, wr_addr_out} !== {1'b0, 18'd182999}) begin
      $display("FAIL last_write_tready: got tready=%0b addr=%0d expected tready=0 addr=182999",
               pixel_tready, wr_addr_out);
      fails++;
    end
    drive(390, 390, 24'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({pixel_tready, wr_en_out, rd_bank_out} !== 3'b000) begin
        $display("FAIL wait_swap_stall: got tready=%0b en=%0b rb=%0b expected 000",
                 pixel_tready, wr_en_out, rd_bank_out);
        fails++;
      end
    end
    display_nf_in = 1'b1;
    step();
    display_nf_in = 1'b0;
    tests++;
    if ({rd_bank_out, frame_done_out, frames_out, pixel_tready, wr_en_out} !== {1'b1, 1'b1, 16'd1, 1'b1, 1'b0}) begin
      $display("FAIL swap: got rb=%0b fd=%0b frames=%0d tready=%0b en=%0b expected rb=1 fd=1 frames=1 tready=1 en=0",
               rd_bank_out, frame_done_out, frames_out, pixel_tready, wr_en_out);
      fails++;
    end
    step();
    pixel_tvalid = 1'b0;
    tests++;
    if ({frame_done_out, wr_en_out, wr_addr_out} !== {1'b0, 1'b1, 18'd0}) begin
      $display("FAIL bank0_write: got fd=%0b en=%0b addr=%0d expected fd=0 en=1 addr=0",
               frame_done_out, wr_en_out, wr_addr_out);
      fails++;
    end
  endtask

  task automatic test_nf_same_cycle();
    drive(633, 764, 24'h0);
    display_nf_in = 1'b1;
    step();
    pixel_tvalid  = 1'b0;
    display_nf_in = 1'b0;
    tests++;
    if ({rd_bank_out, frame_done_out, frames_out, wr_en_out, wr_addr_out, pixel_tready} !==
        {1'b1, 1'b0, 16'd1, 1'b1, 18'd91499, 1'b0}) begin
      $display("FAIL nf_same_cycle: got rb=%0b fd=%0b frames=%0d en=%0b addr=%0d tready=%0b expected rb=1 fd=0 frames=1 en=1 addr=91499 tready=0",
               rd_bank_out, frame_done_out, frames_out, wr_en_out, wr_addr_out, pixel_tready);
      fails++;
    end
    step();
    display_nf_in = 1'b1;
    step();
    display_nf_in = 1'b0;
    tests++;
    if ({rd_bank_out, frame_done_out, frames_out} !== {1'b0, 1'b1, 16'd2}) begin
      $display("FAIL nf_next_pulse: got rb=%0b fd=%0b frames=%0d expected rb=0 fd=1 frames=2",
               rd_bank_out, frame_done_out, frames_out);
      fails++;
    end
  endtask

  task automatic test_nf_in_fill();
    step();
    display_nf_in = 1'b1;
    step();
    display_nf_in = 1'b0;
    tests++;
    if ({rd_bank_out, frame_done_out, frames_out, pixel_tready} !== {1'b0, 1'b0, 16'd2, 1'b1}) begin
      $display("FAIL nf_in_fill: got rb=%0b fd=%0b frames=%0d tready=%0b expected rb=0 fd=0 frames=2 tready=1",
               rd_bank_out, frame_done_out, frames_out, pixel_tready);
      fails++;
    end
  endtask

  task automatic test_async_reset();
    drive(633, 764, 24'h0);
    step();
    tests++;
    if ({wr_en_out, wr_addr_out, pixel_tready} !== {1'b1, 18'd182999, 1'b0}) begin
      $display("FAIL pre_reset_last: got en=%0b addr=%0d tready=%0b expected en=1 addr=182999 tready=0",
               wr_en_out, wr_addr_out, pixel_tready);
      fails++;
    end
    drive(390, 390, 24'h0);
    #2;
    rst_in = 1'b1;
    #1;
    tests++;
    if ({wr_en_out, frame_done_out, rd_bank_out, wr_addr_out, wr_data_out, frames_out, dropped_out} !== '0) begin
      $display("FAIL async_reset_outputs: got en=%0b fd=%0b rb=%0b addr=%0d data=%h frames=%0d dropped=%0d expected all 0",
               wr_en_out, frame_done_out, rd_bank_out, wr_addr_out, wr_data_out, frames_out, dropped_out);
      fails++;
    end
    tests++;
    if (pixel_tready !== 1'b1) begin
      $display("FAIL async_reset_tready: got %0b expected 1", pixel_tready); fails++;
    end
    step();
    rst_in = 1'b0;
    step();
    pixel_tvalid = 1'b0;
    tests++;
    if ({wr_en_out, wr_addr_out, rd_bank_out} !== {1'b1, 18'd91500, 1'b0}) begin
      $display("FAIL post_reset_write: got en=%0b addr=%0d rb=%0b expected en=1 addr=91500 rb=0",
               wr_en_out, wr_addr_out, rd_bank_out);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_first_pixels();
    test_dropped();
    test_frame_swap();
    test_nf_same_cycle();
    test_nf_in_fill();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
